// File: rtl/lsu_dccm_arb_if.sv
// LSU / store-buffer / DMA request and grant bundle for the DCCM bank arbiter.
interface lsu_dccm_arb_if #(
  parameter int unsigned DCCM_BITS = 16
);
  logic                 freeze;
  logic                 ld_req;
  logic [DCCM_BITS-1:0] ld_addr_lo;
  logic [DCCM_BITS-1:0] ld_addr_hi;
  logic                 stb_req;
  logic [DCCM_BITS-1:0] stb_addr;
  logic                 dma_req;
  logic                 ld_gnt;
  logic                 stb_gnt;
  logic                 dma_gnt;
  logic                 lsu_stall;

  modport master (
    output freeze, ld_req, ld_addr_lo, ld_addr_hi, stb_req, stb_addr, dma_req,
    input  ld_gnt, stb_gnt, dma_gnt, lsu_stall
  );

  modport slave (
    input  freeze, ld_req, ld_addr_lo, ld_addr_hi, stb_req, stb_addr, dma_req,
    output ld_gnt, stb_gnt, dma_gnt, lsu_stall
  );
endinterface

// File: rtl/lsu_dccm_arb.sv
// DCCM bank arbiter between LSU loads, store-buffer drains and DMA, with
// starvation-forced grants enabled by the RV_DCCM_ARB_STARVE_EN macro.
module lsu_dccm_arb #(
  parameter int unsigned STARVE_MAX = 15,
  parameter int unsigned DCCM_BITS  = 16,
  parameter int unsigned WIDTH_BITS = 2,
  parameter int unsigned BANK_BITS  = 2
) (
  input  logic                clk,
  input  logic                rst,
  lsu_dccm_arb_if.slave       arb,
  output logic [1:0]          arb_state,
  output logic [7:0]          stb_starve_cnt,
  output logic [7:0]          dma_starve_cnt
);

`ifdef RV_DCCM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  localparam logic [7:0] CNT_MAX = 8'(STARVE_MAX);

  typedef enum logic [1:0] {
    NORMAL    = 2'b00,
    STB_FORCE = 2'b01,
    DMA_FORCE = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] stb_cnt_q, stb_cnt_d;
  logic [7:0] dma_cnt_q, dma_cnt_d;
  logic       ld_gnt, stb_gnt, dma_gnt, lsu_stall;
  logic       conflict;

  function automatic logic [BANK_BITS-1:0] bank_of(input logic [DCCM_BITS-1:0] addr);
    return addr[WIDTH_BITS +: BANK_BITS];
  endfunction

  // Counter clears whenever its requester is idle or served; saturates while starved.
  function automatic logic [7:0] next_cnt(input logic req, input logic gnt, input logic [7:0] cnt);
    if (!req || gnt)      return '0;
    else if (cnt >= CNT_MAX) return CNT_MAX;
    else                  return cnt + 8'd1;
  endfunction

  always_comb begin
    conflict = (bank_of(arb.stb_addr) == bank_of(arb.ld_addr_lo)) ||
               (bank_of(arb.stb_addr) == bank_of(arb.ld_addr_hi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= NORMAL;
      stb_cnt_q <= '0;
      dma_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      stb_cnt_q <= stb_cnt_d;
      dma_cnt_q <= dma_cnt_d;
    end
  end

  always_comb begin
    ld_gnt    = 1'b0;
    stb_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    lsu_stall = 1'b0;
    state_d   = state_q;
    stb_cnt_d = stb_cnt_q;
    dma_cnt_d = dma_cnt_q;

    if (!rst && !arb.freeze) begin
      case (state_q)
        STB_FORCE: begin
          stb_gnt   = arb.stb_req;
          lsu_stall = arb.ld_req;
        end
        DMA_FORCE: begin
          dma_gnt   = arb.dma_req;
          lsu_stall = arb.ld_req;
        end
        default: begin
          ld_gnt  = arb.ld_req;
          dma_gnt = arb.dma_req & ~arb.ld_req;
          stb_gnt = arb.stb_req & ~dma_gnt & (~arb.ld_req | ~conflict);
        end
      endcase

      stb_cnt_d = next_cnt(arb.stb_req, stb_gnt, stb_cnt_q);
      dma_cnt_d = next_cnt(arb.dma_req, dma_gnt, dma_cnt_q);

      // A FORCE state never re-enters itself, so STB_FORCE can chain straight into DMA_FORCE.
      if (state_q != STB_FORCE && stb_cnt_q == CNT_MAX)
        state_d = STB_FORCE;
      else if (state_q != DMA_FORCE && dma_cnt_q == CNT_MAX)
        state_d = DMA_FORCE;
      else
        state_d = NORMAL;
    end

    if (!STARVE_EN) begin
      state_d   = NORMAL;
      stb_cnt_d = '0;
      dma_cnt_d = '0;
    end
  end

  assign arb.ld_gnt     = ld_gnt;
  assign arb.stb_gnt    = stb_gnt;
  assign arb.dma_gnt    = dma_gnt;
  assign arb.lsu_stall  = lsu_stall;
  assign arb_state      = state_q;
  assign stb_starve_cnt = stb_cnt_q;
  assign dma_starve_cnt = dma_cnt_q;

endmodule

// File: tb/tb_lsu_dccm_arb.sv
// Scoreboard bench: two arbiters (STARVE_MAX 3 and 15) share stimulus and are
// checked against a rule-level reference model of the arbitration policy.
module tb_lsu_dccm_arb;

`ifdef RV_DCCM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  typedef struct packed {
    logic        rst, frz, ld;
    logic [15:0] lo, hi;
    logic        stb;
    logic [15:0] sa;
    logic        dma;
  } stim_t;

  typedef struct packed {
    logic       ld, stb, dma, stall;
    logic [1:0] st;
    logic [7:0] sc, dc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_dccm_arb_if #(.DCCM_BITS(16)) if3 ();
  lsu_dccm_arb_if #(.DCCM_BITS(16)) if15 ();
  logic [1:0] st3, st15;
  logic [7:0] sc3, dc3, sc15, dc15;

  lsu_dccm_arb #(.STARVE_MAX(3), .DCCM_BITS(16), .WIDTH_BITS(2), .BANK_BITS(2)) u_dut3 (
    .clk(clk), .rst(rst), .arb(if3.slave),
    .arb_state(st3), .stb_starve_cnt(sc3), .dma_starve_cnt(dc3)
  );
  lsu_dccm_arb #(.STARVE_MAX(15), .DCCM_BITS(16), .WIDTH_BITS(2), .BANK_BITS(2)) u_dut15 (
    .clk(clk), .rst(rst), .arb(if15.slave),
    .arb_state(st15), .stb_starve_cnt(sc15), .dma_starve_cnt(dc15)
  );

  int n_checks = 0;
  int n_errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  int m_max[2] = '{3, 15};
  int m_state[2];
  int m_sc[2];
  int m_dc[2];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: bank = (addr / 4) mod 4; policy applied rule by rule.
  task automatic model_cycle(input int k, input stim_t s, output exp_t e);
    int ns;
    int b_st, b_lo, b_hi;
    bit conf;
    e    = '0;
    e.st = 2'(m_state[k]);
    e.sc = 8'(m_sc[k]);
    e.dc = 8'(m_dc[k]);
    if (s.rst) begin
      m_state[k] = 0;
      m_sc[k]    = 0;
      m_dc[k]    = 0;
    end else if (!s.frz) begin
      b_st = (int'(s.sa) / 4) % 4;
      b_lo = (int'(s.lo) / 4) % 4;
      b_hi = (int'(s.hi) / 4) % 4;
      conf = (b_st == b_lo) || (b_st == b_hi);
      if (m_state[k] == 1) begin
        e.stb = s.stb; e.stall = s.ld;
      end else if (m_state[k] == 2) begin
        e.dma = s.dma; e.stall = s.ld;
      end else begin
        e.ld  = s.ld;
        e.dma = s.dma && !s.ld;
        e.stb = s.stb && !e.dma && !(s.ld && conf);
      end
      if (STARVE_EN) begin
        ns = 0;
        if (m_state[k] != 1 && m_sc[k] == m_max[k]) ns = 1;
        else if (m_state[k] != 2 && m_dc[k] == m_max[k]) ns = 2;
        m_sc[k] = (s.stb && !e.stb) ? ((m_sc[k] < m_max[k]) ? m_sc[k] + 1 : m_max[k]) : 0;
        m_dc[k] = (s.dma && !e.dma) ? ((m_dc[k] < m_max[k]) ? m_dc[k] + 1 : m_max[k]) : 0;
        m_state[k] = ns;
      end
    end
  endtask

  task automatic apply(input stim_t s);
    rst = s.rst;
    if3.freeze  = s.frz; if3.ld_req  = s.ld; if3.ld_addr_lo  = s.lo; if3.ld_addr_hi  = s.hi;
    if3.stb_req = s.stb; if3.stb_addr = s.sa; if3.dma_req = s.dma;
    if15.freeze  = s.frz; if15.ld_req  = s.ld; if15.ld_addr_lo  = s.lo; if15.ld_addr_hi  = s.hi;
    if15.stb_req = s.stb; if15.stb_addr = s.sa; if15.dma_req = s.dma;
  endtask

  task automatic drive(input stim_t s);
    exp_t e0, e1;
    @(posedge clk);
    #1;
    apply(s);
    model_cycle(0, s, e0);
    model_cycle(1, s, e1);
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  function automatic stim_t mk(input bit r, input bit f, input bit ld, input logic [15:0] lo,
                               input logic [15:0] hi, input bit stb, input logic [15:0] sa,
                               input bit dma);
    stim_t s;
    s.rst = r; s.frz = f; s.ld = ld; s.lo = lo; s.hi = hi;
    s.stb = stb; s.sa = sa; s.dma = dma;
    return s;
  endfunction

  task automatic compare(input string tag, input exp_t a, input exp_t e);
    chk({tag, ".ld_gnt"},    int'(a.ld),    int'(e.ld));
    chk({tag, ".stb_gnt"},   int'(a.stb),   int'(e.stb));
    chk({tag, ".dma_gnt"},   int'(a.dma),   int'(e.dma));
    chk({tag, ".lsu_stall"}, int'(a.stall), int'(e.stall));
    chk({tag, ".arb_state"}, int'(a.st),    int'(e.st));
    chk({tag, ".stb_cnt"},   int'(a.sc),    int'(e.sc));
    chk({tag, ".dma_cnt"},   int'(a.dc),    int'(e.dc));
    chk({tag, ".dma_excl"},  int'(a.dma && (a.ld || a.stb)), 0);
  endtask

  always @(negedge clk) begin
    exp_t a, e;
    if (q0.size() > 0 && q1.size() > 0) begin
      e = q0.pop_front();
      a.ld = if3.ld_gnt; a.stb = if3.stb_gnt; a.dma = if3.dma_gnt; a.stall = if3.lsu_stall;
      a.st = st3; a.sc = sc3; a.dc = dc3;
      compare("m3", a, e);
      e = q1.pop_front();
      a.ld = if15.ld_gnt; a.stb = if15.stb_gnt; a.dma = if15.dma_gnt; a.stall = if15.lsu_stall;
      a.st = st15; a.sc = sc15; a.dc = dc15;
      compare("m15", a, e);
    end
  end

  localparam logic [15:0] B0 = 16'h0000, B1 = 16'h0004, B2 = 16'h0008, B3 = 16'h010C;

  initial begin
    stim_t s;
    apply(mk(1'b1, 1'b0, 1'b1, B1, B1, 1'b1, B1, 1'b1));
    repeat (2) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_sc[k] = 0; m_dc[k] = 0;
    end

    // reset held with all requests active: no grants
    repeat (2) drive(mk(1'b1, 1'b0, 1'b1, B1, B1, 1'b1, B1, 1'b1));
    // ld bank1, stb bank2: co-grant
    repeat (3) drive(mk(1'b0, 1'b0, 1'b1, B1, B1, 1'b1, B2, 1'b0));
    // conflicting ld/stb held: stb starvation forces a grant
    repeat (10) drive(mk(1'b0, 1'b0, 1'b1, B1, B1, 1'b1, 16'h0104, 1'b0));
    repeat (2) drive(mk(1'b0, 1'b0, 1'b0, B0, B0, 1'b0, B0, 1'b0));
    // ld + dma held: dma starvation
    repeat (20) drive(mk(1'b0, 1'b0, 1'b1, B2, B3, 1'b0, B0, 1'b1));
    repeat (2) drive(mk(1'b0, 1'b0, 1'b0, B0, B0, 1'b0, B0, 1'b0));
    // both starve together (conflict via hi address)
    repeat (20) drive(mk(1'b0, 1'b0, 1'b1, B0, B1, 1'b1, B1, 1'b1));
    repeat (2) drive(mk(1'b0, 1'b0, 1'b0, B0, B0, 1'b0, B0, 1'b0));
    // freeze in the middle of contention
    repeat (6) drive(mk(1'b0, 1'b0, 1'b1, B3, B3, 1'b1, B3, 1'b1));
    repeat (5) drive(mk(1'b0, 1'b1, 1'b1, B3, B3, 1'b1, B3, 1'b1));
    repeat (6) drive(mk(1'b0, 1'b0, 1'b1, B3, B3, 1'b1, B3, 1'b1));
    repeat (2) drive(mk(1'b0, 1'b0, 1'b0, B0, B0, 1'b0, B0, 1'b0));
    // reset while the 3-cycle arbiter is in STB_FORCE
    repeat (4) drive(mk(1'b0, 1'b0, 1'b1, B2, B2, 1'b1, B2, 1'b0));
    drive(mk(1'b1, 1'b0, 1'b1, B2, B2, 1'b1, B2, 1'b0));
    repeat (2) drive(mk(1'b0, 1'b0, 1'b0, B0, B0, 1'b0, B0, 1'b0));

    s = mk(1'b0, 1'b0, 1'b0, B0, B0, 1'b0, B0, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        s.ld  = ($urandom_range(0, 9) < 7);
        s.stb = ($urandom_range(0, 9) < 7);
        s.dma = ($urandom_range(0, 9) < 4);
        s.lo  = 16'($urandom);
        s.hi  = 16'($urandom);
        s.sa  = 16'($urandom);
      end
      s.frz = ($urandom_range(0, 15) == 0);
      s.rst = ($urandom_range(0, 99) == 0);
      drive(s);
    end
    repeat (2) drive(mk(1'b0, 1'b0, 1'b0, B0, B0, 1'b0, B0, 1'b0));

    repeat (3) @(negedge clk);
    chk("queue_drained", q0.size() + q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
